// File: rtl/yedi_segment_surucu.sv
// yedi_segment_surucu
// Drives a 4-digit common-anode 7-segment display from a 4-bit count.
//   - The count arrives from a slower counter stage, so it is synchronised
//     and only accepted once two consecutive samples agree.
//   - The display is scanned D0 (ones), D1 (tens, zero-suppressed),
//     D2 (always blank), D3 (whole value as one hex character).
//   - Optional macro DEGISIM_NOKTA_EN: after each accepted change the
//     decimal point of the ones digit lights for NOKTA_SURE clk cycles.
//     Without the macro dp is tied high and no timer exists.
// All outputs are active-low and registered; reset is synchronous, active-low.

module yedi_segment_surucu #(
    parameter int YENILEME_BOLEN = 50000,
    parameter int NOKTA_SURE     = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sayacdegeri,
    output logic [6:0] segment,
    output logic [3:0] anot,
    output logic       dp
);

    localparam int BOLEN_W = (YENILEME_BOLEN > 2) ? $clog2(YENILEME_BOLEN) : 1;
    localparam logic [BOLEN_W-1:0] BOLEN_SON = BOLEN_W'(YENILEME_BOLEN - 1);
    localparam logic [6:0] BOS = 7'b1111111;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } durum_t;

    // Parameter sanity: a divider below 2 or a zero-length pulse is meaningless.
    generate
        if (YENILEME_BOLEN < 2 || NOKTA_SURE < 1) begin : g_gecersiz_parametre
            $error("yedi_segment_surucu: YENILEME_BOLEN must be >= 2 and NOKTA_SURE >= 1");
        end
    endgenerate

    // Active-low {g,f,e,d,c,b,a} pattern for one hex character.
    function automatic logic [6:0] hex_kodla(input logic [3:0] deger);
        logic [6:0] kod;
        case (deger)
            4'h0:    kod = 7'b1000000;
            4'h1:    kod = 7'b1111001;
            4'h2:    kod = 7'b0100100;
            4'h3:    kod = 7'b0110000;
            4'h4:    kod = 7'b0011001;
            4'h5:    kod = 7'b0010010;
            4'h6:    kod = 7'b0000010;
            4'h7:    kod = 7'b1111000;
            4'h8:    kod = 7'b0000000;
            4'h9:    kod = 7'b0010000;
            4'hA:    kod = 7'b0001000;
            4'hB:    kod = 7'b0000011;
            4'hC:    kod = 7'b1000110;
            4'hD:    kod = 7'b0100001;
            4'hE:    kod = 7'b0000110;
            default: kod = 7'b0001110;
        endcase
        return kod;
    endfunction

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    // senk_reg[0], senk_reg[1]: two-flop synchroniser; senk_reg[2]: previous
    // synchronised sample used for the two-sample agreement test.
    logic [2:0][3:0] senk_reg;
    logic [3:0]      goruntu_reg;
    logic            yukle;

    // Shift the raw count through the synchroniser and sample-history chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            senk_reg <= '0;
        end else begin
            senk_reg[0] <= sayacdegeri;
            senk_reg[1] <= senk_reg[0];
            senk_reg[2] <= senk_reg[1];
        end
    end

    // Accept a new value only when two consecutive synchronised samples agree;
    // a value present for a single cycle can never satisfy this.
    assign yukle = (senk_reg[1] == senk_reg[2]) && (senk_reg[1] != goruntu_reg);

    // Display register: holds the value currently being shown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            goruntu_reg <= 4'd0;
        end else if (yukle) begin
            goruntu_reg <= senk_reg[1];
        end
    end

    // Decimal split of 0..15 into tens (0/1) and ones (0..9).
    logic       onlar;
    logic [3:0] birler;
    assign onlar  = (goruntu_reg >= 4'd10);
    assign birler = onlar ? (goruntu_reg - 4'd10) : goruntu_reg;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [BOLEN_W-1:0] bolen_reg;
    logic               tasma;

    assign tasma = (bolen_reg == BOLEN_SON);

    // Slot prescaler: one full count per digit slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bolen_reg <= '0;
        end else if (tasma) begin
            bolen_reg <= '0;
        end else begin
            bolen_reg <= bolen_reg + BOLEN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    durum_t durum_reg;
    durum_t durum_next;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum_reg <= D0;
        end else begin
            durum_reg <= durum_next;
        end
    end

    // Next state: advance one digit on every prescaler wrap.
    always_comb begin
        durum_next = durum_reg;
        if (tasma) begin
            case (durum_reg)
                D0:      durum_next = D1;
                D1:      durum_next = D2;
                D2:      durum_next = D3;
                default: durum_next = D0;
            endcase
        end
    end

    // One select line per digit, bit index equals the digit number.
    logic [3:0] slot_sec;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot_sec
            assign slot_sec[gi] = (durum_reg == durum_t'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Change indicator
    // ------------------------------------------------------------------
    logic nokta_aktif;

`ifdef DEGISIM_NOKTA_EN
    localparam int NOKTA_W = $clog2(NOKTA_SURE + 1);
    logic [NOKTA_W-1:0] nokta_sayac_reg;

    // Pulse timer: every accepted change restarts the full duration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nokta_sayac_reg <= '0;
        end else if (yukle) begin
            nokta_sayac_reg <= NOKTA_W'(NOKTA_SURE);
        end else if (nokta_sayac_reg != '0) begin
            nokta_sayac_reg <= nokta_sayac_reg - NOKTA_W'(1);
        end
    end

    assign nokta_aktif = (nokta_sayac_reg != '0);
`else
    assign nokta_aktif = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [6:0] segment_next;
    logic [3:0] anot_next;
    logic       dp_next;
    logic [6:0] segment_reg;
    logic [3:0] anot_reg;
    logic       dp_reg;

    // Output decode for the active slot.
    always_comb begin
        segment_next = BOS;
        anot_next    = ~slot_sec;
        dp_next      = 1'b1;
        case (durum_reg)
            D0: begin
                segment_next = hex_kodla(birler);
                dp_next      = ~nokta_aktif;
            end
            D1:      segment_next = onlar ? hex_kodla(4'd1) : BOS;
            D2:      segment_next = BOS;
            default: segment_next = hex_kodla(goruntu_reg);
        endcase
    end

    // Output registers: segment, anot and dp always change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segment_reg <= BOS;
            anot_reg    <= 4'b1111;
            dp_reg      <= 1'b1;
        end else begin
            segment_reg <= segment_next;
            anot_reg    <= anot_next;
            dp_reg      <= dp_next;
        end
    end

    assign segment = segment_reg;
    assign anot    = anot_reg;
    assign dp      = dp_reg;

endmodule

// File: tb/tb_yedi_segment_surucu.sv
// Testbench for yedi_segment_surucu (YENILEME_BOLEN=4, NOKTA_SURE=20).
// Each driven cycle pushes the expected {anot, segment, dp} for the next
// edge; a monitor pops and compares after every rising edge.

module tb_yedi_segment_surucu;

    localparam int BOLEN = 4;
    localparam int NOKTA = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sayacdegeri = 4'd0;
    logic [6:0] segment;
    logic [3:0] anot;
    logic       dp;

    always #5 clk = ~clk;

    yedi_segment_surucu #(
        .YENILEME_BOLEN(BOLEN),
        .NOKTA_SURE    (NOKTA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sayacdegeri(sayacdegeri),
        .segment    (segment),
        .anot       (anot),
        .dp         (dp)
    );

    int kontrol_sayisi = 0;
    int hata_sayisi    = 0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // Encoding table taken directly from the display datasheet values.
    function automatic logic [6:0] kod(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // ---------------- reference model (edge-history based) ----------------
    logic [11:0] beklenen_q[$];
    logic [3:0]  ornek[0:4095];   // value the DUT samples at each edge
    int          kenar = 3;
    int          m_goruntu = 0;
    int          m_rel = 0;       // edges since reset release
    int          m_son_yukleme = -1000;

    task automatic adim(input logic r, input logic [3:0] v);
        logic [11:0] bek;
        logic [6:0]  sg;
        logic [3:0]  an;
        logic        d;
        int          slot;
        rst_n = r;
        sayacdegeri = v;
        kenar++;
        if (!r) begin
            // reset clears the synchroniser and history stages
            ornek[kenar]     = 4'd0;
            ornek[kenar - 1] = 4'd0;
            ornek[kenar - 2] = 4'd0;
            m_goruntu = 0;
            m_rel = 0;
            m_son_yukleme = -1000;
            bek = {4'b1111, 7'b1111111, 1'b1};
        end else begin
            ornek[kenar] = v;
            m_rel++;
            slot = ((m_rel - 1) / BOLEN) % 4;
            d = 1'b1;
            case (slot)
                0: begin an = 4'b1110; sg = kod(m_goruntu % 10); end
                1: begin an = 4'b1101; sg = (m_goruntu >= 10) ? kod(1) : 7'b1111111; end
                2: begin an = 4'b1011; sg = 7'b1111111; end
                default: begin an = 4'b0111; sg = kod(m_goruntu); end
            endcase
`ifdef DEGISIM_NOKTA_EN
            if (slot == 0 && m_son_yukleme >= kenar - NOKTA && m_son_yukleme <= kenar - 1)
                d = 1'b0;
`endif
            bek = {an, sg, d};
            // display register accepts the value once two samples agree
            if (ornek[kenar - 2] == ornek[kenar - 3] && int'(ornek[kenar - 2]) != m_goruntu) begin
                m_goruntu = int'(ornek[kenar - 2]);
                m_son_yukleme = kenar;
            end
        end
        beklenen_q.push_back(bek);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tut(input logic [3:0] v, input int n);
        repeat (n) adim(1'b1, v);
    endtask

    // ---------------- monitor ----------------
    logic [11:0] m_bek;
    logic [6:0]  slot_seg[4];
    logic [3:0]  onceki_anot = 4'b1111;
    int          kosu = 0;
    logic        gordu9 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (beklenen_q.size() > 0) begin
            m_bek = beklenen_q.pop_front();
            kontrol("cikis", {20'd0, anot, segment, dp}, {20'd0, m_bek});
        end
        case (anot)
            4'b1110: slot_seg[0] = segment;
            4'b1101: slot_seg[1] = segment;
            4'b1011: slot_seg[2] = segment;
            4'b0111: slot_seg[3] = segment;
            default: ;
        endcase
        if (anot == 4'b1110 && segment == 7'b0010000) gordu9 = 1'b1;
        if (anot == onceki_anot) begin
            kosu++;
        end else begin
            if (onceki_anot != 4'b1111 && anot != 4'b1111)
                kontrol("slot_uzunlugu", kosu, BOLEN);
            kosu = 1;
        end
        onceki_anot = anot;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rv;
        int         rn;
        for (int i = 0; i < 4; i++) ornek[i] = 4'd0;

        repeat (3) adim(1'b0, 4'd0);
        kontrol("reset_anot", anot, 4'b1111);
        kontrol("reset_segment", segment, 7'b1111111);
        kontrol("reset_dp", dp, 1'b1);

        // first released edge shows D0 with the cleared display value
        adim(1'b1, 4'd12);
        kontrol("ilk_d0_anot", anot, 4'b1110);
        kontrol("ilk_d0_segment", segment, 7'b1000000);
        tut(4'd12, 39);
        kontrol("on2_d0", slot_seg[0], 7'b0100100);
        kontrol("on2_d1", slot_seg[1], 7'b1111001);
        kontrol("on2_d2", slot_seg[2], 7'b1111111);
        kontrol("on2_d3", slot_seg[3], 7'b1000110);

        tut(4'd7, 40);
        kontrol("yedi_d0", slot_seg[0], 7'b1111000);
        kontrol("yedi_d1", slot_seg[1], 7'b1111111);
        kontrol("yedi_d3", slot_seg[3], 7'b1111000);

        // single-cycle glitch must never be displayed
        tut(4'd5, 40);
        gordu9 = 1'b0;
        adim(1'b1, 4'd9);
        tut(4'd5, 40);
        kontrol("glitch_gorulmedi", gordu9, 1'b0);
        kontrol("glitch_d0", slot_seg[0], 7'b0010010);

        // wrap 15 -> 0 -> 15
        tut(4'd15, 40);
        kontrol("onbes_d0", slot_seg[0], 7'b0010010);
        kontrol("onbes_d1", slot_seg[1], 7'b1111001);
        kontrol("onbes_d3", slot_seg[3], 7'b0001110);
        tut(4'd0, 40);
        kontrol("sifir_d0", slot_seg[0], 7'b1000000);
        kontrol("sifir_d1", slot_seg[1], 7'b1111111);
        kontrol("sifir_d3", slot_seg[3], 7'b1000000);
        tut(4'd15, 40);
        kontrol("geri_d3", slot_seg[3], 7'b0001110);

        // one-edge reset in the middle of the D2 slot
        while (((m_rel / BOLEN) % 4) != 2) adim(1'b1, 4'd15);
        adim(1'b1, 4'd15);
        kontrol("d2_ortasi", anot, 4'b1011);
        adim(1'b0, 4'd15);
        kontrol("orta_reset_anot", anot, 4'b1111);
        kontrol("orta_reset_segment", segment, 7'b1111111);
        kontrol("orta_reset_dp", dp, 1'b1);
        adim(1'b1, 4'd9);
        kontrol("yeniden_d0_anot", anot, 4'b1110);
        kontrol("yeniden_d0_segment", segment, 7'b1000000);
        tut(4'd9, 40);
        kontrol("yeniden_dokuz_d0", slot_seg[0], 7'b0010000);

        // random holds, including single-cycle values
        repeat (40) begin
            rv = 4'($urandom_range(0, 15));
            rn = $urandom_range(1, 10);
            tut(rv, rn);
        end
        tut(4'd3, 30);

        kontrol("kuyruk_bos", beklenen_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/yedi_segment_surucu.md
YEDI_SEGMENT_SURUCU -- requirements
Module: yedi_segment_surucu

Interface
REQ-001 Parameter YENILEME_BOLEN, default 50000: clk cycles per digit scan slot; legal range >= 2.
REQ-002 Parameter NOKTA_SURE, default 25000000: clk cycles the change-indicator dp stays lit; legal range >= 1.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 sayacdegeri  input  4  binary count from the up/down counter stage; changes on its divided clock, asynchronous to this block's sampling.
REQ-006 segment  output  7  active-low segments, order {g,f,e,d,c,b,a}; registered.
REQ-007 anot  output  4  active-low one-hot digit enables; bit0 is the rightmost digit; registered.
REQ-008 dp  output  1  active-low decimal point; registered.

Function
REQ-009 sayacdegeri SHALL pass through a 2-flop synchronizer; a third register SHALL hold the previous synchronized sample.
REQ-010 Display register goruntu SHALL load the synchronized value only when the synchronized value and the previous sample are equal and differ from goruntu; single-cycle glitches SHALL never reach goruntu.
REQ-011 Latency: a stable input change SHALL appear in goruntu on the 3rd clk edge after it is sampled, and on segment/anot one edge later if that digit's slot is active.
REQ-012 goruntu (0-15) SHALL split into decimal tens (0/1) and ones (0-9) combinationally.
REQ-013 Prescaler SHALL count 0..YENILEME_BOLEN-1 and wrap; on the wrap the scan FSM SHALL advance one state.
REQ-014 Scan FSM states D0->D1->D2->D3->D0: D0 ones digit, anot=1110; D1 tens digit, anot=1101; D2 blank, anot=1011; D3 goruntu as one hex character 0-F, anot=0111.
REQ-015 D1 SHALL be blank (segment=1111111) when tens is 0 (leading-zero suppression); D2 SHALL always be blank.
REQ-016 Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
REQ-017 Exactly one anot bit SHALL be low in every cycle after the first post-reset cycle; segment and anot SHALL change on the same edge.
REQ-018 Wrap-around 15->0 and 0->15 SHALL be treated as ordinary value changes; no special display.

Reset
REQ-019 While rst_n=0 at a clk edge: segment=1111111, anot=1111, dp=1, prescaler=0, FSM=D0, goruntu=0, synchronizer and sample registers=0, dp timer=0.
REQ-020 First edge with rst_n=1 SHALL drive the D0 slot (anot=1110, segment=1000000).
REQ-021 Reset asserted mid-slot or mid-dp-pulse SHALL abort it; no partial state survives.

Configuration
REQ-022 Macro DEGISIM_NOKTA_EN defined: every goruntu load SHALL (re)start a timer of NOKTA_SURE cycles; while running, dp=0 during D0 and dp=1 in other slots; a new change mid-pulse restarts the full duration.
REQ-023 Macro DEGISIM_NOKTA_EN undefined: dp SHALL be constant 1 and no timer logic SHALL be synthesized.

Verification (YENILEME_BOLEN=4, NOKTA_SURE=20)
REQ-024 Reset, then sayacdegeri=12 held -> D0 segment=0100100, D1 1111001, D2 1111111, D3 1000110; each slot exactly 4 cycles, anot sequence 1110,1101,1011,0111.
REQ-025 sayacdegeri=7 -> D0 1111000, D1 blank 1111111, D3 1111000.
REQ-026 Hold 5, pulse input to 9 for one clk cycle -> goruntu stays 5; D0 never shows 0010000.
REQ-027 Count 15 then 0 (wrap) -> D1 goes from 1111001 to blank, D0 and D3 show 1000000; with DEGISIM_NOKTA_EN, dp=0 in D0 slots for 20 cycles after the load, else dp=1 throughout.
REQ-028 rst_n=0 for one edge during D2 -> next output anot=1111, segment=1111111, dp=1; after release, scan restarts at D0 with goruntu=0 until a stable input is reloaded.
